// File: rtl/eq_pkg.sv
// eq_pkg: pot index and scan state enums, A2D channel map, index helpers
package eq_pkg;

  typedef enum logic [2:0] {
    IDX_LP,
    IDX_B1,
    IDX_B2,
    IDX_B3,
    IDX_HP,
    IDX_VOL
  } pot_idx_e;

  typedef enum logic [1:0] {
    GAP,
    START,
    WAIT,
    UPDATE
  } scan_state_e;

  localparam int NUM_POTS = 6;

  localparam logic [2:0] CH_LP  = 3'd1;
  localparam logic [2:0] CH_B1  = 3'd0;
  localparam logic [2:0] CH_B2  = 3'd4;
  localparam logic [2:0] CH_B3  = 3'd2;
  localparam logic [2:0] CH_HP  = 3'd3;
  localparam logic [2:0] CH_VOL = 3'd7;

  function automatic logic [2:0] chan_of(pot_idx_e idx);
    return idx == IDX_LP ? CH_LP :
           idx == IDX_B1 ? CH_B1 :
           idx == IDX_B2 ? CH_B2 :
           idx == IDX_B3 ? CH_B3 :
           idx == IDX_HP ? CH_HP : CH_VOL;
  endfunction

  function automatic pot_idx_e next_idx(pot_idx_e idx);
    return idx == IDX_VOL ? IDX_LP : pot_idx_e'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/pot_scan_sequencer_if.sv
// pot_scan_sequencer_if: conversion handshake between the scan sequencer and the A2D SPI front end
interface pot_scan_sequencer_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
  modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/pot_scan_sequencer_timer.sv
// pot_scan_timer: loadable down-counter with hold and zero flag, shared by gap and timeout timing
module pot_scan_timer #(
  parameter int           W       = 13,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  // load has priority; otherwise count down while enabled, parking at zero
  always_comb cnt_d = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
  // count register, preset so the first gap after reset is a full one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pot_scan_sequencer.sv
// pot_scan_sequencer: round-robin A2D scan of six EQ pots; POT_SMOOTH_EN enables averaging of new samples with the held value
module pot_scan_sequencer
  import eq_pkg::*;
#(
  parameter int SCAN_GAP = 1024,
  parameter int TIMEOUT  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pot_scan_sequencer_if.master a2d,
  input  logic                 freeze,
  output logic [11:0]          POT_LP,
  output logic [11:0]          POT_B1,
  output logic [11:0]          POT_B2,
  output logic [11:0]          POT_B3,
  output logic [11:0]          POT_HP,
  output logic [11:0]          POT_VOL,
  output logic                 pots_vld,
  output logic                 sweep_done,
  output logic                 cnv_err
);
  localparam int TW = $clog2(SCAN_GAP > TIMEOUT ? SCAN_GAP : TIMEOUT) + 1;
  localparam logic [TW-1:0] GAP_LD = TW'(SCAN_GAP - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);

  scan_state_e         state_q, state_d;
  pot_idx_e            idx_q, idx_d;
  logic [11:0]         res_q, res_d, wr_val;
  logic [11:0]         pot_q [NUM_POTS];
  logic [11:0]         pot_d [NUM_POTS];
  logic [NUM_POTS-1:0] seen_q, seen_d;
  logic                pots_vld_q, pots_vld_d;
  logic                tmr_load, tmr_en, tmr_zero, timeout, upd, adv;
  logic [TW-1:0]       tmr_val;

  pot_scan_timer #(.W(TW), .RST_VAL(GAP_LD)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // scan FSM: gap countdown (held by freeze), one-cycle start, bounded wait, one-cycle update
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = GAP_LD;
    tmr_en   = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      GAP: begin
        tmr_en = !freeze;
        if (tmr_zero && !freeze) state_d = START;
      end
      START: begin
        tmr_load = 1'b1;
        tmr_val  = TO_LD;
        state_d  = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (a2d.cnv_cmplt) state_d = UPDATE;
        else if (tmr_zero) begin
          timeout  = 1'b1;
          tmr_load = 1'b1;
          state_d  = GAP;
        end
      end
      UPDATE: begin
        tmr_load = 1'b1;
        state_d  = GAP;
      end
      default: state_d = GAP;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= GAP;
    else state_q <= state_d;

  assign upd = state_q == UPDATE;
  assign adv = upd || timeout;

`ifdef POT_SMOOTH_EN
  assign wr_val = pots_vld_q ? 12'(({1'b0, pot_q[idx_q]} + {1'b0, res_q} + 13'd1) >> 1) : res_q;
`else
  assign wr_val = res_q;
`endif

  // datapath next state: result capture, pot write, index advance, coverage of converted pots
  always_comb begin
    idx_d      = adv ? next_idx(idx_q) : idx_q;
    res_d      = (state_q == WAIT && a2d.cnv_cmplt) ? a2d.res : res_q;
    seen_d     = upd ? seen_q | (NUM_POTS'(1) << idx_q) : seen_q;
    pots_vld_d = pots_vld_q || (upd && idx_q == IDX_VOL && &seen_d);
    pot_d      = pot_q;
    if (upd) pot_d[idx_q] = wr_val;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q      <= IDX_LP;
      res_q      <= '0;
      seen_q     <= '0;
      pots_vld_q <= 1'b0;
      pot_q      <= '{default: '0};
    end else begin
      idx_q      <= idx_d;
      res_q      <= res_d;
      seen_q     <= seen_d;
      pots_vld_q <= pots_vld_d;
      pot_q      <= pot_d;
    end

  assign a2d.strt_cnv = state_q == START;
  assign a2d.chnnl    = chan_of(idx_q);
  assign sweep_done   = adv && idx_q == IDX_VOL;
  assign cnv_err      = timeout;
  assign pots_vld     = pots_vld_q;
  assign POT_LP       = pot_q[IDX_LP];
  assign POT_B1       = pot_q[IDX_B1];
  assign POT_B2       = pot_q[IDX_B2];
  assign POT_B3       = pot_q[IDX_B3];
  assign POT_HP       = pot_q[IDX_HP];
  assign POT_VOL      = pot_q[IDX_VOL];
endmodule

// File: tb/tb_pot_scan_sequencer.sv
// tb_pot_scan_sequencer: directed scenarios for the pot scan sequencer with SCAN_GAP=16, TIMEOUT=64
module tb_pot_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol;
  logic pots_vld, sweep_done, cnv_err;
  int n_cmp = 0;
  int n_err = 0;

`ifdef POT_SMOOTH_EN
  localparam logic [11:0] E_LP2 = 12'd1051, E_B1_2 = 12'd0, E_B3_2 = 12'd211, E_HP2 = 12'd317, E_VOL2 = 12'd739;
  localparam logic [11:0] E_LP3 = 12'd2026, E_B1_3 = 12'd278, E_B2_3 = 12'd422;
`else
  localparam logic [11:0] E_LP2 = 12'd2001, E_B1_2 = 12'd0, E_B3_2 = 12'd222, E_HP2 = 12'd333, E_VOL2 = 12'd777;
  localparam logic [11:0] E_LP3 = 12'd3000, E_B1_3 = 12'd555, E_B2_3 = 12'd444;
`endif

  pot_scan_sequencer_if a2d ();

  pot_scan_sequencer #(.SCAN_GAP(16), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a2d        (a2d),
    .freeze     (freeze),
    .POT_LP     (pot_lp),
    .POT_B1     (pot_b1),
    .POT_B2     (pot_b2),
    .POT_B3     (pot_b3),
    .POT_HP     (pot_hp),
    .POT_VOL    (pot_vol),
    .pots_vld   (pots_vld),
    .sweep_done (sweep_done),
    .cnv_err    (cnv_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic wait_strt(input int bound, output int cyc, output logic [2:0] ch);
    cyc = -1;
    ch  = 3'bx;
    for (int i = 1; i <= bound && cyc < 0; i++) begin
      @(negedge clk);
      if (a2d.strt_cnv) begin
        cyc = i;
        ch  = a2d.chnnl;
      end
    end
  endtask

  task automatic a2d_reply(input int dly, input logic [11:0] val);
    repeat (dly) @(negedge clk);
    a2d.cnv_cmplt = 1'b1;
    a2d.res       = val;
    @(negedge clk);
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
  endtask

  task automatic test_reset;
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, pots_vld, sweep_done, cnv_err, a2d.strt_cnv} !== '0) begin n_err++; $display("FAIL reset_outputs: got %h required 0", {pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, pots_vld, sweep_done, cnv_err, a2d.strt_cnv}); end
    n_cmp++; if (a2d.chnnl !== 3'd1) begin n_err++; $display("FAIL reset_chnnl: got %0d required 1", a2d.chnnl); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_conv;
    int cyc;
    logic [2:0] ch;
    wait_strt(40, cyc, ch);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL first_gap: got %0d required 16", cyc); end
    n_cmp++; if (ch !== 3'd1) begin n_err++; $display("FAIL first_chnnl: got %0d required 1", ch); end
    @(negedge clk);
    n_cmp++; if (a2d.strt_cnv !== 1'b0) begin n_err++; $display("FAIL strt_single: got %b required 0", a2d.strt_cnv); end
    n_cmp++; if (a2d.chnnl !== 3'd1) begin n_err++; $display("FAIL chnnl_stable: got %0d required 1", a2d.chnnl); end
    a2d_reply(19, 12'd100);
    n_cmp++; if (pot_lp !== 12'd0) begin n_err++; $display("FAIL lp_before_update: got %0d required 0", pot_lp); end
    @(negedge clk);
    n_cmp++; if (pot_lp !== 12'd100) begin n_err++; $display("FAIL lp_update: got %0d required 100", pot_lp); end
  endtask

  task automatic test_full_sweep;
    int cyc;
    logic [2:0] ch;
    logic [2:0] chs [5];
    logic [11:0] vals [5];
    chs  = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    vals = '{12'd0, 12'd400, 12'd200, 12'd300, 12'd700};
    for (int k = 0; k < 5; k++) begin
      wait_strt(40, cyc, ch);
      n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL sweep_gap[%0d]: got %0d required 16", k, cyc); end
      n_cmp++; if (ch !== chs[k]) begin n_err++; $display("FAIL sweep_chnnl[%0d]: got %0d required %0d", k, ch, chs[k]); end
      a2d_reply(20, vals[k]);
      n_cmp++; if (sweep_done !== (k == 4)) begin n_err++; $display("FAIL sweep_done_upd[%0d]: got %b required %b", k, sweep_done, k == 4); end
      n_cmp++; if (pots_vld !== 1'b0) begin n_err++; $display("FAIL vld_before_wrap[%0d]: got %b required 0", k, pots_vld); end
      @(negedge clk);
      n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL sweep_done_single[%0d]: got %b required 0", k, sweep_done); end
      n_cmp++; if (pots_vld !== (k == 4)) begin n_err++; $display("FAIL vld_after_upd[%0d]: got %b required %b", k, pots_vld, k == 4); end
    end
    n_cmp++; if ({pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol} !== {12'd100, 12'd0, 12'd400, 12'd200, 12'd300, 12'd700}) begin n_err++; $display("FAIL sweep_pots: got %0d %0d %0d %0d %0d %0d required 100 0 400 200 300 700", pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol); end
  endtask

  task automatic test_smooth;
    int cyc;
    logic [2:0] ch;
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd1) begin n_err++; $display("FAIL wrap_chnnl: got %0d required 1", ch); end
    a2d_reply(20, 12'd2001);
    @(negedge clk);
    n_cmp++; if (pot_lp !== E_LP2) begin n_err++; $display("FAIL lp_second_sweep: got %0d required %0d", pot_lp, E_LP2); end
    wait_strt(40, cyc, ch);
    a2d_reply(20, 12'd0);
    @(negedge clk);
    n_cmp++; if (pot_b1 !== E_B1_2) begin n_err++; $display("FAIL b1_second_sweep: got %0d required %0d", pot_b1, E_B1_2); end
  endtask

  task automatic test_timeout;
    int cyc;
    logic [2:0] ch;
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd4) begin n_err++; $display("FAIL to_chnnl: got %0d required 4", ch); end
    cyc = -1;
    for (int i = 1; i <= 100 && cyc < 0; i++) begin
      @(negedge clk);
      if (cnv_err) cyc = i;
    end
    n_cmp++; if (cyc !== 64) begin n_err++; $display("FAIL to_cycle: got %0d required 64", cyc); end
    n_cmp++; if (pot_b2 !== 12'd400) begin n_err++; $display("FAIL to_b2_kept: got %0d required 400", pot_b2); end
    @(negedge clk);
    n_cmp++; if (cnv_err !== 1'b0) begin n_err++; $display("FAIL to_err_single: got %b required 0", cnv_err); end
    wait_strt(40, cyc, ch);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL to_gap: got %0d required 16", cyc); end
    n_cmp++; if (ch !== 3'd2) begin n_err++; $display("FAIL to_next_chnnl: got %0d required 2", ch); end
    a2d_reply(20, 12'd222);
    @(negedge clk);
    wait_strt(40, cyc, ch);
    a2d_reply(20, 12'd333);
    @(negedge clk);
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd7) begin n_err++; $display("FAIL sweep2_vol_chnnl: got %0d required 7", ch); end
    a2d_reply(20, 12'd777);
    n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL sweep2_done: got %b required 1", sweep_done); end
    @(negedge clk);
    n_cmp++; if ({pot_b2, pot_b3, pot_hp, pot_vol} !== {12'd400, E_B3_2, E_HP2, E_VOL2}) begin n_err++; $display("FAIL sweep2_pots: got %0d %0d %0d %0d required 400 %0d %0d %0d", pot_b2, pot_b3, pot_hp, pot_vol, E_B3_2, E_HP2, E_VOL2); end
    n_cmp++; if (pots_vld !== 1'b1) begin n_err++; $display("FAIL vld_sticky: got %b required 1", pots_vld); end
  endtask

  task automatic test_coincident;
    int cyc;
    logic [2:0] ch;
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd1) begin n_err++; $display("FAIL coinc_chnnl: got %0d required 1", ch); end
    repeat (64) @(negedge clk);
    a2d.cnv_cmplt = 1'b1;
    a2d.res       = 12'd3000;
    #1;
    n_cmp++; if (cnv_err !== 1'b0) begin n_err++; $display("FAIL coinc_no_err: got %b required 0", cnv_err); end
    @(negedge clk);
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
    @(negedge clk);
    n_cmp++; if (pot_lp !== E_LP3) begin n_err++; $display("FAIL coinc_lp: got %0d required %0d", pot_lp, E_LP3); end
  endtask

  task automatic test_freeze;
    int cyc;
    logic [2:0] ch;
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd0) begin n_err++; $display("FAIL freeze_chnnl: got %0d required 0", ch); end
    repeat (5) @(negedge clk);
    freeze = 1'b1;
    a2d_reply(15, 12'd555);
    @(negedge clk);
    n_cmp++; if (pot_b1 !== E_B1_3) begin n_err++; $display("FAIL freeze_cur_update: got %0d required %0d", pot_b1, E_B1_3); end
    cyc = 0;
    repeat (30) begin
      @(negedge clk);
      if (a2d.strt_cnv) cyc++;
    end
    n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL freeze_no_strt: got %0d starts required 0", cyc); end
    freeze = 1'b0;
    wait_strt(40, cyc, ch);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL freeze_resume_gap: got %0d required 16", cyc); end
    n_cmp++; if (ch !== 3'd4) begin n_err++; $display("FAIL freeze_resume_chnnl: got %0d required 4", ch); end
    a2d_reply(20, 12'd444);
    @(negedge clk);
    n_cmp++; if (pot_b2 !== E_B2_3) begin n_err++; $display("FAIL b2_third_sweep: got %0d required %0d", pot_b2, E_B2_3); end
    repeat (5) @(negedge clk);
    freeze = 1'b1;
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (a2d.strt_cnv) cyc++;
    end
    n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL midgap_freeze_no_strt: got %0d starts required 0", cyc); end
    freeze = 1'b0;
    wait_strt(40, cyc, ch);
    n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL held_count_resume: got %0d required 11", cyc); end
    n_cmp++; if (ch !== 3'd2) begin n_err++; $display("FAIL held_count_chnnl: got %0d required 2", ch); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [2:0] ch;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, pots_vld, sweep_done, cnv_err, a2d.strt_cnv} !== '0) begin n_err++; $display("FAIL async_reset_outputs: got %h required 0", {pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, pots_vld, sweep_done, cnv_err, a2d.strt_cnv}); end
    n_cmp++; if (a2d.chnnl !== 3'd1) begin n_err++; $display("FAIL async_reset_chnnl: got %0d required 1", a2d.chnnl); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a2d.cnv_cmplt = 1'b1;
    a2d.res       = 12'd999;
    @(negedge clk);
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
    @(negedge clk);
    n_cmp++; if ({pot_lp, pot_b3} !== 24'd0) begin n_err++; $display("FAIL stray_ignored: got %0d %0d required 0 0", pot_lp, pot_b3); end
    wait_strt(40, cyc, ch);
    n_cmp++; if (cyc !== 13) begin n_err++; $display("FAIL restart_gap: got %0d required 13", cyc); end
    n_cmp++; if (ch !== 3'd1) begin n_err++; $display("FAIL restart_chnnl: got %0d required 1", ch); end
    a2d_reply(20, 12'd123);
    @(negedge clk);
    n_cmp++; if (pot_lp !== 12'd123) begin n_err++; $display("FAIL restart_lp: got %0d required 123", pot_lp); end
  endtask

  task automatic test_skip_vol;
    int cyc;
    logic [2:0] ch;
    logic [11:0] vals [4];
    vals = '{12'd11, 12'd22, 12'd33, 12'd44};
    for (int k = 0; k < 4; k++) begin
      wait_strt(40, cyc, ch);
      a2d_reply(20, vals[k]);
      @(negedge clk);
    end
    n_cmp++; if ({pot_b1, pot_b2, pot_b3, pot_hp} !== {12'd11, 12'd22, 12'd33, 12'd44}) begin n_err++; $display("FAIL skip_pre_pots: got %0d %0d %0d %0d required 11 22 33 44", pot_b1, pot_b2, pot_b3, pot_hp); end
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd7) begin n_err++; $display("FAIL skip_vol_chnnl: got %0d required 7", ch); end
    cyc = -1;
    for (int i = 1; i <= 100 && cyc < 0; i++) begin
      @(negedge clk);
      if (cnv_err) cyc = i;
    end
    n_cmp++; if (cyc !== 64) begin n_err++; $display("FAIL skip_vol_to_cycle: got %0d required 64", cyc); end
    n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL skip_vol_done: got %b required 1", sweep_done); end
    @(negedge clk);
    n_cmp++; if (pots_vld !== 1'b0) begin n_err++; $display("FAIL skip_vol_no_vld: got %b required 0", pots_vld); end
    n_cmp++; if (pot_vol !== 12'd0) begin n_err++; $display("FAIL skip_vol_kept: got %0d required 0", pot_vol); end
    wait_strt(40, cyc, ch);
    n_cmp++; if (ch !== 3'd1) begin n_err++; $display("FAIL skip_vol_wrap_chnnl: got %0d required 1", ch); end
  endtask

  initial begin
    test_reset;
    test_first_conv;
    test_full_sweep;
    test_smooth;
    test_timeout;
    test_coincident;
    test_freeze;
    test_reset_mid;
    test_skip_vol;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pot_scan_sequencer.md
POT_SCAN_SEQUENCER -- requirements
Module: pot_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_GAP, default 1024: idle clk cycles between successive conversion starts.
REQ-002 SHALL have parameter TIMEOUT, default 4096: max clk cycles to wait for cnv_cmplt before abandoning a conversion.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port strt_cnv  output  1  single-cycle request to A2D SPI interface to start a conversion.
REQ-006 SHALL have port chnnl  output  3  A2D channel select for current conversion.
REQ-007 SHALL have port cnv_cmplt  input  1  single-cycle pulse from A2D interface; res valid this cycle.
REQ-008 SHALL have port res  input  12  unsigned conversion result.
REQ-009 SHALL have port freeze  input  1  level; when high, no new conversions start.
REQ-010 SHALL have ports POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL  output  12 each  registered pot values feeding the EQ datapath.
REQ-011 SHALL have port pots_vld  output  1  level; high once every pot has been converted at least once.
REQ-012 SHALL have port sweep_done  output  1  single-cycle pulse when a full six-channel sweep finishes.
REQ-013 SHALL have port cnv_err  output  1  single-cycle pulse on conversion timeout.

Function
REQ-014 SHALL implement FSM states GAP, START, WAIT, UPDATE; GAP is entered from reset.
REQ-015 SHALL, in GAP, count SCAN_GAP cycles, then go to START; counter holds (not cleared) while freeze=1.
REQ-016 SHALL, in START, assert strt_cnv for exactly one cycle and go to WAIT.
REQ-017 SHALL drive chnnl from the current index via the package channel map (LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7), stable from START until leaving WAIT.
REQ-018 SHALL, in WAIT, capture res on cnv_cmplt and go to UPDATE; cnv_cmplt in any other state SHALL be ignored.
REQ-019 SHALL, in UPDATE, write the indexed POT register, advance index LP->B1->B2->B3->HP->VOL->LP, and return to GAP (one cycle).
REQ-020 SHALL update a POT output exactly one clk after the cnv_cmplt that produced it; other POT outputs unchanged.
REQ-021 SHALL pulse sweep_done in the UPDATE cycle where index wraps VOL->LP; SHALL set pots_vld on the first such wrap and keep it high until reset.
REQ-022 SHALL, if WAIT lasts TIMEOUT cycles without cnv_cmplt, pulse cnv_err, keep the old POT value, advance index, and go to GAP; a skipped VOL still produces sweep_done but SHALL NOT set pots_vld.
REQ-023 SHALL let a conversion already in START/WAIT complete normally when freeze rises.
REQ-024 SHALL treat cnv_cmplt coincident with timeout expiry as a completion (no cnv_err).

Reset
REQ-025 SHALL, on rst_n low, immediately clear all POT outputs, pots_vld, sweep_done, cnv_err, strt_cnv, index (=LP), counters, and force state GAP, including mid-conversion.

Configuration
REQ-026 SHALL, with POT_SMOOTH_EN defined, write POT = (old + res + 1) >> 1 (13-bit sum) when pots_vld=1 and raw res otherwise.
REQ-027 SHALL, without POT_SMOOTH_EN, always write raw res.

Structure
REQ-028 SHALL place channel-map constants, pot index enum, and FSM state enum in shared package eq_pkg.
REQ-029 SHALL use one sub-module pot_scan_timer (loadable down-counter with hold and zero flag), shared between gap and timeout timing.

Verification
REQ-030 Reset, SCAN_GAP=16, A2D model returns ch*100 after 20 cycles -> first strt_cnv 16 cycles after reset release with chnnl=1; POT_LP=100 one cycle after cnv_cmplt.
REQ-031 Full sweep -> chnnl order 1,0,4,2,3,7; POT_VOL=700; sweep_done one pulse; pots_vld rises with it.
REQ-032 A2D silent on chnnl=4, TIMEOUT=64 -> cnv_err at cycle 64 of WAIT, POT_B2 unchanged, next strt_cnv uses chnnl=2.
REQ-033 freeze=1 during WAIT -> current POT updates, then no strt_cnv until freeze=0; gap resumes from held count.
REQ-034 POT_SMOOTH_EN, POT_LP=1000, res=2001 on second sweep -> POT_LP=1501.
REQ-035 rst_n asserted in WAIT -> all outputs 0 asynchronously; a later stray cnv_cmplt is ignored; scan restarts at chnnl=1.
